// File: rtl/regfile_wb_scheduler_pkg.sv
// +--------------------------------------------------------------------+
// | regfile_sched_pkg : shared sizes and types for the writeback sched |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package regfile_sched_pkg;
    localparam int XLEN         = 64;
    localparam int NREG         = 32;
    localparam int REG_AW       = 5;
    localparam int STARVE_LIMIT = 4;

    typedef logic [REG_AW-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]   xdata_t;
endpackage

`default_nettype wire

// File: rtl/regfile_wb_scheduler_scoreboard.sv
// +--------------------------------------------------------------------+
// | wb_scoreboard : busy bits of long-latency destinations + hazards   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module wb_scoreboard
    import regfile_sched_pkg::*;
#(
    parameter int NUM_REGS = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                iss_valid_i,
    input  logic                iss_long_i,
    input  reg_idx_t            iss_rd_i,
    input  reg_idx_t            iss_rs1_i,
    input  reg_idx_t            iss_rs2_i,
    input  logic                clr_en_i,
    input  reg_idx_t            clr_idx_i,
    output logic                iss_stall_o,
    output logic [NUM_REGS-1:0] busy_o
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic                w_hazard;
    logic                w_set_en;

    assign w_hazard    = busy_q[iss_rs1_i] | busy_q[iss_rs2_i] | busy_q[iss_rd_i];
    assign iss_stall_o = iss_valid_i & w_hazard;
    assign w_set_en    = iss_valid_i & ~iss_stall_o & iss_long_i & (iss_rd_i != '0);
    assign busy_o      = busy_q;

    // Set applied after clear: the issuing instruction is the newer owner.
    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) busy_d[clr_idx_i] = 1'b0;
        if (w_set_en) busy_d[iss_rd_i]  = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

endmodule

`default_nettype wire

// File: rtl/regfile_wb_scheduler.sv
// +--------------------------------------------------------------------+
// | regfile_wb_scheduler : write-port arbiter, starve guard, scoreboard |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module regfile_wb_scheduler #(
    parameter int XLEN         = regfile_sched_pkg::XLEN,
    parameter int NREG         = regfile_sched_pkg::NREG,
    parameter int STARVE_LIMIT = regfile_sched_pkg::STARVE_LIMIT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        a_valid,
    output logic                        a_ready,
    input  regfile_sched_pkg::reg_idx_t a_rd,
    input  logic [XLEN-1:0]             a_data,
    input  logic                        b_valid,
    output logic                        b_ready,
    input  regfile_sched_pkg::reg_idx_t b_rd,
    input  logic [XLEN-1:0]             b_data,
    input  logic                        iss_valid,
    input  logic                        iss_long,
    input  regfile_sched_pkg::reg_idx_t iss_rd,
    input  regfile_sched_pkg::reg_idx_t iss_rs1,
    input  regfile_sched_pkg::reg_idx_t iss_rs2,
    output logic                        iss_stall,
    output logic                        RegWrite,
    output regfile_sched_pkg::reg_idx_t RD,
    output logic [XLEN-1:0]             WriteData,
    output logic [NREG-1:0]             busy_vec
);

    localparam int c_STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_LIMIT);

    logic [c_STARVE_W-1:0]       starve_cnt_q, starve_cnt_d;
    logic                        regwrite_q, regwrite_d;
    regfile_sched_pkg::reg_idx_t rd_q, rd_d;
    logic [XLEN-1:0]             wdata_q, wdata_d;

    logic w_force_b;
    logic w_a_hs;
    logic w_b_hs;
    logic w_sb_stall;

    // Ready outputs are gated by reset so nothing handshakes while it is held.
    assign w_force_b = b_valid & (starve_cnt_q == c_STARVE_MAX);
    assign a_ready   = reset & ~w_force_b;
    assign b_ready   = reset & b_valid & (~a_valid | w_force_b);
    assign w_a_hs    = a_valid & a_ready;
    assign w_b_hs    = b_valid & b_ready;
    assign iss_stall = ~reset | w_sb_stall;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!b_valid || w_b_hs)             starve_cnt_d = '0;
        else if (starve_cnt_q != c_STARVE_MAX) starve_cnt_d = starve_cnt_q + 1'b1;
    end

    always_comb begin
        regwrite_d = 1'b0;
        rd_d       = rd_q;
        wdata_d    = wdata_q;
        if (w_a_hs) begin
            regwrite_d = (a_rd != '0);
            rd_d       = a_rd;
            wdata_d    = a_data;
        end else if (w_b_hs) begin
            regwrite_d = (b_rd != '0);
            rd_d       = b_rd;
            wdata_d    = b_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt_q <= '0;
            regwrite_q   <= 1'b0;
            rd_q         <= '0;
            wdata_q      <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            regwrite_q   <= regwrite_d;
            rd_q         <= rd_d;
            wdata_q      <= wdata_d;
        end
    end

    assign RegWrite  = regwrite_q;
    assign RD        = rd_q;
    assign WriteData = wdata_q;

    wb_scoreboard #(
        .NUM_REGS (NREG)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (reset),
        .iss_valid_i (iss_valid),
        .iss_long_i  (iss_long),
        .iss_rd_i    (iss_rd),
        .iss_rs1_i   (iss_rs1),
        .iss_rs2_i   (iss_rs2),
        .clr_en_i    (w_b_hs),
        .clr_idx_i   (b_rd),
        .iss_stall_o (w_sb_stall),
        .busy_o      (busy_vec)
    );

endmodule

`default_nettype wire
